cdr_lock_ctrl: RTL and testbench
================================

CDR_LOCK_CTRL -- requirements
Module: cdr_lock_ctrl

Interface
REQ-001 SHALL have parameter C_F, default 32'd14658591, nominal CDR frequency word (2^32*F_cdr/F_clk).
REQ-002 SHALL have parameter STEP, default 32'd4096, sweep step added to or subtracted from the frequency word per window.
REQ-003 SHALL have parameter SPAN, default 32'd1048576, maximum deviation of the frequency word from C_F.
REQ-004 SHALL have parameter WIN, default 1024, evaluation window length in clk cycles (WIN >= 2).
REQ-005 SHALL have parameter TOL, default 8, maximum |balance| for a window to count as good.
REQ-006 SHALL have parameter LOCK_WINS, default 4, consecutive good windows required in TRACK to declare lock.
REQ-007 SHALL have parameter LOSS_WINS, default 3, consecutive bad windows in LOCKED that declare loss of lock.
REQ-008 clk  input  1  high-frequency system clock; all logic is on posedge clk.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 en  input  1  acquisition enable, level.
REQ-011 nrz_edge  input  1  one-cycle pulse per detected NRZ transition.
REQ-012 cdr_phase  input  1  recovered-clock MSB, sampled in the same cycle as nrz_edge.
REQ-013 fword  output  32  frequency word driven to the CDR.
REQ-014 fword_load  output  1  one-cycle strobe asserted in the cycle fword takes a new value.
REQ-015 locked  output  1  high while in LOCKED.
REQ-016 lol  output  1  one-cycle loss-of-lock pulse.
REQ-017 state  output  2  current state code: IDLE=0, SWEEP=1, TRACK=2, LOCKED=3.

Function
REQ-018 Window meter: a free-running counter 0..WIN-1; the terminal cycle is count WIN-1; the counter restarts at 0 on entry to SWEEP.
REQ-019 balance: signed 16-bit, saturating at +/-32767; it increments on nrz_edge&cdr_phase, decrements on nrz_edge&~cdr_phase, and is cleared after each terminal cycle.
REQ-020 An nrz_edge in the terminal cycle counts toward the closing window.
REQ-021 A window is good iff it contained >=1 edge and |balance| <= TOL; a window with 0 edges is bad.
REQ-022 IDLE -> SWEEP when en=1; fword holds C_F.
REQ-023 SWEEP, bad window with balance > 0: fword <= max(fword-STEP, C_F-SPAN), with fword_load.
REQ-024 SWEEP, bad window with balance < 0: fword <= min(fword+STEP, C_F+SPAN), with fword_load.
REQ-025 SWEEP, bad window with balance = 0 (no edges): fword is unchanged and no fword_load is issued.
REQ-026 fword_load is not asserted when clamping leaves fword unchanged.
REQ-027 SWEEP -> TRACK on a good window; the good-window count is set to 1.
REQ-028 TRACK: a good window increments the count, and reaching LOCK_WINS moves to LOCKED; a bad window returns to SWEEP with the count cleared.
REQ-029 LOCKED: a bad window increments the bad count, and a good window clears it; reaching LOSS_WINS pulses lol for one cycle and moves to SWEEP.
REQ-030 fword is constant in TRACK and LOCKED.
REQ-031 en=0 in any non-IDLE state: next state is IDLE, fword <= C_F with fword_load (if changed), locked=0, no lol pulse.
REQ-032 en=0 has priority over a same-cycle window evaluation.
REQ-033 All state transitions and fword updates take effect on the clk edge that ends the terminal cycle (1-cycle latency).

Reset
REQ-034 While rst=1: state=IDLE, fword=C_F, fword_load=0, locked=0, lol=0, balance=0, window and all window counts=0.
REQ-035 rst asserted mid-window discards that window; no fword_load is issued by reset.

Structure
REQ-036 Package cdr_pkg SHALL hold the state enum (IDLE, SWEEP, TRACK, LOCKED) and the C_F default constant.
REQ-037 Sub-module cdr_win_meter SHALL contain the window counter, balance accumulator, edge-seen flag and good/bad/sign outputs, with a one-cycle window-done strobe.

Verification
REQ-038 Reset with en=1 and no edges for 3 windows -> state=SWEEP, fword=C_F, no fword_load.
REQ-039 Every edge has cdr_phase=1 for 5 windows -> fword=C_F-5*STEP, 5 fword_load pulses each 1 cycle wide.
REQ-040 Sweep pinned at the upper bound for SPAN/STEP+3 windows -> fword=C_F+SPAN, with exactly SPAN/STEP load pulses.
REQ-041 Balanced edges (+/-2 per window) for 5 windows -> TRACK after window 1, LOCKED after window 4, locked=1.
REQ-042 In LOCKED, 2 bad windows, 1 good, then 3 bad -> lol pulses once at the end of window 6, then state=SWEEP.
REQ-043 en dropped in the terminal cycle of a window in SWEEP with fword!=C_F -> IDLE next cycle, fword=C_F, one fword_load, no step applied.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared state encoding and default frequency word for the CDR lock controller.
package cdr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } cdr_state_e;

  localparam logic [31:0] CDR_C_F_DEFAULT = 32'd14658591;

endpackage

// File: rtl/cdr_win_meter.sv
// Fixed-length evaluation window: counts cycles, accumulates the phase balance of
// NRZ edges and grades the window on its terminal cycle.
module cdr_win_meter #(
  parameter int WIN = 1024,
  parameter int TOL = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic nrz_edge_i,
  input  logic cdr_phase_i,
  output logic done_o,
  output logic good_o,
  output logic pos_o,
  output logic neg_o
);

  localparam int CW = $clog2(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);
  localparam logic signed [15:0] BAL_MAX = 16'sd32767;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [15:0] bal_q, bal_d, bal_abs;
  logic               seen_q, seen_d;

  // Grading uses the post-update balance so an edge in the terminal cycle
  // still belongs to the window that is closing.
  always_comb begin
    bal_d = bal_q;
    if (nrz_edge_i && cdr_phase_i && (bal_q != BAL_MAX))
      bal_d = bal_q + 16'sd1;
    else if (nrz_edge_i && !cdr_phase_i && (bal_q != -BAL_MAX))
      bal_d = bal_q - 16'sd1;
    seen_d  = seen_q | nrz_edge_i;
    bal_abs = bal_d[15] ? -bal_d : bal_d;
    done_o  = (cnt_q == LAST);
    cnt_d   = done_o ? '0 : cnt_q + 1'b1;
    good_o  = seen_d && (32'(bal_abs) <= TOL);
    pos_o   = (bal_d > 16'sd0);
    neg_o   = bal_d[15];
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q  <= '0;
      bal_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bal_q  <= done_o ? 16'sd0 : bal_d;
      seen_q <= done_o ? 1'b0 : seen_d;
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR frequency acquisition and lock supervisor: sweeps the frequency word toward
// balanced phase, then tracks and supervises lock window by window.
//   IDLE   | disabled, fword parked at C_F, window meter held clear
//   SWEEP  | step fword against the sign of each bad window's balance
//   TRACK  | fword frozen, counting consecutive good windows
//   LOCKED | lock declared, counting consecutive bad windows
module cdr_lock_ctrl
  import cdr_pkg::*;
#(
  parameter logic [31:0] C_F       = CDR_C_F_DEFAULT,
  parameter logic [31:0] STEP      = 32'd4096,
  parameter logic [31:0] SPAN      = 32'd1048576,
  parameter int          WIN       = 1024,
  parameter int          TOL       = 8,
  parameter int          LOCK_WINS = 4,
  parameter int          LOSS_WINS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        nrz_edge,
  input  logic        cdr_phase,
  output logic [31:0] fword,
  output logic        fword_load,
  output logic        locked,
  output logic        lol,
  output logic [1:0]  state
);

  localparam logic [32:0] F_LO_X = {1'b0, C_F} - {1'b0, SPAN};
  localparam logic [32:0] F_HI_X = {1'b0, C_F} + {1'b0, SPAN};
  localparam logic [31:0] F_LO   = F_LO_X[32] ? 32'd0 : F_LO_X[31:0];
  localparam logic [31:0] F_HI   = F_HI_X[32] ? 32'hFFFF_FFFF : F_HI_X[31:0];

  cdr_state_e  state_q, state_d;
  logic [31:0] fword_q, fword_d, fword_dn, fword_up;
  logic [32:0] dn_x, up_x;
  logic        load_q, lol_q, lol_d;
  logic [15:0] good_q, good_d, bad_q, bad_d;
  logic        win_done, win_good, win_pos, win_neg;

  cdr_win_meter #(
    .WIN (WIN),
    .TOL (TOL)
  ) u_meter (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q == IDLE),
    .nrz_edge_i  (nrz_edge),
    .cdr_phase_i (cdr_phase),
    .done_o      (win_done),
    .good_o      (win_good),
    .pos_o       (win_pos),
    .neg_o       (win_neg)
  );

  // Clamped sweep candidates; 33-bit math keeps the bound checks wrap-free.
  always_comb begin
    dn_x     = {1'b0, fword_q} - {1'b0, STEP};
    up_x     = {1'b0, fword_q} + {1'b0, STEP};
    fword_dn = (dn_x[32] || (dn_x[31:0] < F_LO)) ? F_LO : dn_x[31:0];
    fword_up = (up_x > {1'b0, F_HI}) ? F_HI : up_x[31:0];
  end

  always_comb begin
    state_d = state_q;
    fword_d = fword_q;
    good_d  = good_q;
    bad_d   = bad_q;
    lol_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = SWEEP;
      end
      SWEEP: begin
        if (win_done) begin
          if (win_good) begin
            state_d = TRACK;
            good_d  = 16'd1;
          end else if (win_pos) begin
            fword_d = fword_dn;
          end else if (win_neg) begin
            fword_d = fword_up;
          end
        end
      end
      TRACK: begin
        if (win_done) begin
          if (!win_good) begin
            state_d = SWEEP;
            good_d  = '0;
          end else if ({16'd0, good_q} + 32'd1 >= LOCK_WINS) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 16'd1;
          end
        end
      end
      LOCKED: begin
        if (win_done) begin
          if (win_good) begin
            bad_d = '0;
          end else if ({16'd0, bad_q} + 32'd1 >= LOSS_WINS) begin
            state_d = SWEEP;
            bad_d   = '0;
            lol_d   = 1'b1;
          end else begin
            bad_d = bad_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable wins over whatever the closing window decided.
    if ((state_q != IDLE) && !en) begin
      state_d = IDLE;
      fword_d = C_F;
      good_d  = '0;
      bad_d   = '0;
      lol_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fword_q <= C_F;
      load_q  <= 1'b0;
      lol_q   <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      fword_q <= fword_d;
      load_q  <= (fword_d != fword_q);
      lol_q   <= lol_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign fword      = fword_q;
  assign fword_load = load_q;
  assign locked     = (state_q == LOCKED);
  assign lol        = lol_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Self-checking bench for cdr_lock_ctrl: window-level reference model, directed
// vector table and hand-written corner sequences.
module tb_cdr_lock_ctrl;

  localparam logic [31:0] CF    = 32'd14658591;
  localparam logic [31:0] TSTEP = 32'd4096;
  localparam logic [31:0] TSPAN = 32'd24576;
  localparam int TWIN  = 16;
  localparam int TTOL  = 2;
  localparam int TLOCK = 4;
  localparam int TLOSS = 3;
  localparam int S_IDLE = 0, S_SWEEP = 1, S_TRACK = 2, S_LOCKED = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        nrz_edge = 1'b0;
  logic        cdr_phase = 1'b0;
  logic [31:0] fword;
  logic        fword_load, locked, lol;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  int load_cnt, lol_cnt, run_len, max_run;
  int m_state, m_good, m_bad, exp_load, exp_lol;
  longint m_fword;

  typedef struct {
    int np;
    int nn;
    int st;
    int lk;
    int lols;
  } vec_t;
  vec_t vt[11];

  cdr_lock_ctrl #(
    .C_F(CF), .STEP(TSTEP), .SPAN(TSPAN), .WIN(TWIN), .TOL(TTOL),
    .LOCK_WINS(TLOCK), .LOSS_WINS(TLOSS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .nrz_edge(nrz_edge), .cdr_phase(cdr_phase),
    .fword(fword), .fword_load(fword_load), .locked(locked), .lol(lol), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, observe at the next falling edge.
  task automatic cyc(input logic e, input logic p);
    nrz_edge  = e;
    cdr_phase = p;
    @(posedge clk);
    @(negedge clk);
    if (fword_load) begin
      load_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (lol) lol_cnt++;
  endtask

  // Reference: what one finished window does, from its edge totals alone.
  function automatic void model_win(input int bal, input int edges);
    bit good;
    longint nf;
    good = (edges > 0) && (bal <= TTOL) && (bal >= -TTOL);
    case (m_state)
      S_SWEEP: begin
        if (good) begin
          m_state = S_TRACK;
          m_good  = 1;
        end else if (bal != 0) begin
          if (bal > 0) begin
            nf = m_fword - longint'(TSTEP);
            if (nf < longint'(CF) - longint'(TSPAN)) nf = longint'(CF) - longint'(TSPAN);
          end else begin
            nf = m_fword + longint'(TSTEP);
            if (nf > longint'(CF) + longint'(TSPAN)) nf = longint'(CF) + longint'(TSPAN);
          end
          if (nf != m_fword) exp_load++;
          m_fword = nf;
        end
      end
      S_TRACK: begin
        if (good) begin
          m_good++;
          if (m_good >= TLOCK) begin
            m_state = S_LOCKED;
            m_bad   = 0;
          end
        end else begin
          m_state = S_SWEEP;
          m_good  = 0;
        end
      end
      S_LOCKED: begin
        if (good) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad >= TLOSS) begin
            m_state = S_SWEEP;
            m_bad   = 0;
            exp_lol++;
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_win(input int np, input int nn);
    int ev[TWIN];
    int j, t;
    for (int i = 0; i < TWIN; i++) ev[i] = (i < np) ? 1 : ((i < np + nn) ? 2 : 0);
    for (int i = TWIN - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = ev[i]; ev[i] = ev[j]; ev[j] = t;
    end
    for (int i = 0; i < TWIN; i++) cyc(ev[i] != 0, ev[i] == 1);
    model_win(np - nn, np + nn);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"}, state, m_state);
    chk({tag, "_fword"}, fword, m_fword);
    chk({tag, "_locked"}, locked, (m_state == S_LOCKED) ? 1 : 0);
    chk({tag, "_loads"}, load_cnt, exp_load);
    chk({tag, "_lol"}, lol_cnt, exp_lol);
  endtask

  task automatic start();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    chk("rst_state", state, S_IDLE);
    chk("rst_fword", fword, CF);
    chk("rst_load", fword_load, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lol", lol, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    load_cnt = 0; lol_cnt = 0; run_len = 0; max_run = 0;
    m_state = S_SWEEP; m_fword = CF; m_good = 0; m_bad = 0;
    exp_load = 0; exp_lol = 0;
  endtask

  initial begin
    int base, np, nn, mode;
    vt[0]  = '{2, 2, S_TRACK, 0, 0};
    vt[1]  = '{2, 2, S_TRACK, 0, 0};
    vt[2]  = '{2, 2, S_TRACK, 0, 0};
    vt[3]  = '{2, 2, S_LOCKED, 1, 0};
    vt[4]  = '{2, 2, S_LOCKED, 1, 0};
    vt[5]  = '{0, 0, S_LOCKED, 1, 0};
    vt[6]  = '{6, 0, S_LOCKED, 1, 0};
    vt[7]  = '{1, 1, S_LOCKED, 1, 0};
    vt[8]  = '{0, 6, S_LOCKED, 1, 0};
    vt[9]  = '{0, 0, S_LOCKED, 1, 0};
    vt[10] = '{5, 0, S_SWEEP, 0, 1};
    @(negedge clk);

    // Silent line: no edges keeps sweeping without touching fword.
    start();
    repeat (3) run_win(0, 0);
    chk("noedge_state", state, S_SWEEP);
    chk("noedge_fword", fword, CF);
    chk("noedge_loads", load_cnt, 0);

    // Phase always high: five steps down, one-cycle strobes.
    start();
    repeat (5) run_win(3, 0);
    chk("down_fword", fword, CF - 5 * TSTEP);
    chk("down_loads", load_cnt, 5);
    chk("down_width", max_run, 1);
    check_model("down");

    // Pinned at the upper bound.
    start();
    repeat (TSPAN / TSTEP + 3) run_win(0, 3);
    chk("clamp_fword", fword, CF + TSPAN);
    chk("clamp_loads", load_cnt, TSPAN / TSTEP);
    check_model("clamp");

    // Lock acquisition, bad-window tolerance and loss of lock.
    start();
    for (int i = 0; i < 11; i++) begin
      run_win(vt[i].np, vt[i].nn);
      chk($sformatf("vec%0d_state", i), state, vt[i].st);
      chk($sformatf("vec%0d_locked", i), locked, vt[i].lk);
      chk($sformatf("vec%0d_lol", i), lol_cnt, vt[i].lols);
      chk($sformatf("vec%0d_fword", i), fword, CF);
      chk($sformatf("vec%0d_loads", i), load_cnt, 0);
    end

    // Disable in the terminal cycle of a stepping window.
    start();
    repeat (2) run_win(0, 3);
    chk("endis_pre_fword", fword, CF + 2 * TSTEP);
    base = load_cnt;
    repeat (3) cyc(1'b1, 1'b1);
    repeat (TWIN - 4) cyc(1'b0, 1'b0);
    en = 1'b0;
    cyc(1'b1, 1'b1);
    chk("endis_state", state, S_IDLE);
    chk("endis_fword", fword, CF);
    chk("endis_load", fword_load, 1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("endis_loads", load_cnt - base, 1);
    chk("endis_lol", lol_cnt, 0);
    chk("endis_idle", state, S_IDLE);

    // Reset mid-window: back to C_F without a load strobe.
    start();
    run_win(0, 3);
    chk("rstmid_pre", fword, CF + TSTEP);
    repeat (5) cyc(1'b1, 1'b0);
    base = load_cnt;
    rst = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);
    chk("rstmid_state", state, S_IDLE);
    chk("rstmid_fword", fword, CF);
    chk("rstmid_loads", load_cnt - base, 0);
    chk("rstmid_locked", locked, 0);

    // Randomized windows against the reference model.
    start();
    for (int w = 0; w < 60; w++) begin
      mode = int'($urandom_range(5, 0));
      np = 0; nn = 0;
      if (mode >= 1 && mode <= 3) begin
        np = int'($urandom_range(6, 1));
        nn = np + int'($urandom_range(4, 0)) - 2;
        if (nn < 0) nn = 0;
      end else if (mode == 4) begin
        np = int'($urandom_range(8, 3));
        nn = int'($urandom_range(np - 3, 0));
      end else if (mode == 5) begin
        nn = int'($urandom_range(8, 3));
        np = int'($urandom_range(nn - 3, 0));
      end
      run_win(np, nn);
      check_model($sformatf("rnd%0d", w));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
